// File: rtl/cdc_chan_arb_pkg.sv
// Shared types and helpers for the cdc_chan_arbiter slice.
package cdc_chan_arb_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOCKED = 3'd1,
      DRAIN  = 3'd2,
      CLEAR  = 3'd3,
      DONE   = 3'd4
   } state_e;

   function automatic int idx_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/cdc_chan_arb_rr_pick.sv
// Combinational round-robin picker: first set valid at or after ptr, with wrap.
module cdc_chan_arb_rr_pick #(
   parameter int NumInp   = 4,
   parameter int IdxWidth = 2
) (
   input  logic [NumInp-1:0]   valid,
   input  logic [IdxWidth-1:0] ptr,
   output logic [IdxWidth-1:0] idx,
   output logic [NumInp-1:0]   onehot,
   output logic                any
);

   // Scan from the pointer upward; the first hit locks out later candidates.
   always_comb begin
      int  j;
      logic hit;
      j      = 0;
      hit    = 1'b0;
      idx    = '0;
      onehot = '0;
      any    = 1'b0;
      for (int i = 0; i < NumInp; i++) begin
         j         = (int'(ptr) + i) % NumInp;
         hit       = valid[j] & ~any;
         onehot[j] = hit;
         idx       = hit ? IdxWidth'(j) : idx;
         any       = any | hit;
      end
   end

endmodule

// File: rtl/cdc_chan_arbiter.sv
// Round-robin front end sharing one cdc_4phase source channel, with 4-phase flush.
// Optional stall watchdog enabled by defining CDC_CHAN_ARB_TIMEOUT_EN.
module cdc_chan_arbiter
   import cdc_chan_arb_pkg::*;
#(
   parameter  int NumInp        = 4,
   parameter  int DataWidth     = 32,
   parameter  int ClrCycles     = 2,
   parameter  int TimeoutCycles = 1024,
   localparam int IdxWidth      = idx_width(NumInp)
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NumInp-1:0][DataWidth-1:0]   inp_data_i,
   input  logic [NumInp-1:0]                  inp_valid_i,
   output logic [NumInp-1:0]                  inp_ready_o,
   output logic [DataWidth+IdxWidth-1:0]      oup_data_o,
   output logic                               oup_valid_o,
   input  logic                               oup_ready_i,
   input  logic                               idle_i,
   output logic                               clr_o,
   input  logic                               flush_req_i,
   output logic                               flush_ack_o,
   output logic                               timeout_o
);

   localparam int ClrW = (ClrCycles > 1) ? $clog2(ClrCycles) : 1;

   state_e              state_q;
   logic [IdxWidth-1:0] rr_q;
   logic [ClrW-1:0]     clr_cnt_q;
   logic [IdxWidth-1:0] pick_idx;
   logic [NumInp-1:0]   pick_onehot;
   logic                pick_any;
   logic [IdxWidth-1:0] held_idx;
   logic                grant;

   cdc_chan_arb_rr_pick #(
      .NumInp   (NumInp),
      .IdxWidth (IdxWidth)
   ) u_pick (
      .valid  (inp_valid_i),
      .ptr    (rr_q),
      .idx    (pick_idx),
      .onehot (pick_onehot),
      .any    (pick_any)
   );

   assign held_idx    = oup_data_o[DataWidth +: IdxWidth];
   assign grant       = (state_q == IDLE) && !flush_req_i && pick_any;
   // Gated by reset so the strobe drops the instant reset asserts.
   assign inp_ready_o = (grant && rst_ni) ? pick_onehot : {NumInp{1'b0}};

   // Arbitration and flush FSM with registered channel-side outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         clr_cnt_q   <= '0;
         oup_data_o  <= '0;
         oup_valid_o <= 1'b0;
         clr_o       <= 1'b0;
         flush_ack_o <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               flush_ack_o <= 1'b0;
               if (flush_req_i) begin
                  state_q <= DRAIN;
               end else if (pick_any) begin
                  oup_data_o  <= {pick_idx, inp_data_i[pick_idx]};
                  oup_valid_o <= 1'b1;
                  state_q     <= LOCKED;
               end
            end
            LOCKED: begin
               if (oup_ready_i) begin
                  oup_valid_o <= 1'b0;
                  rr_q        <= (held_idx == IdxWidth'(NumInp - 1)) ? '0 : held_idx + 1'b1;
                  state_q     <= IDLE;
               end
            end
            DRAIN: begin
               if (idle_i) begin
                  clr_o     <= 1'b1;
                  clr_cnt_q <= ClrW'(ClrCycles - 1);
                  state_q   <= CLEAR;
               end
            end
            CLEAR: begin
               if (clr_cnt_q == '0) begin
                  clr_o       <= 1'b0;
                  flush_ack_o <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  clr_cnt_q <= clr_cnt_q - 1'b1;
               end
            end
            DONE: begin
               if (!flush_req_i) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q     <= IDLE;
               oup_valid_o <= 1'b0;
               clr_o       <= 1'b0;
               flush_ack_o <= 1'b0;
            end
         endcase
      end
   end

`ifdef CDC_CHAN_ARB_TIMEOUT_EN
   localparam int ToW = $clog2(TimeoutCycles + 1);

   logic [ToW-1:0] stall_cnt_q;
   logic           timeout_q;

   // Stall watchdog: counts unanswered LOCKED cycles, sticky until CLEAR entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         if (state_q == LOCKED && !oup_ready_i) begin
            if (stall_cnt_q != ToW'(TimeoutCycles)) begin
               stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (stall_cnt_q == ToW'(TimeoutCycles - 1)) begin
               timeout_q <= 1'b1;
            end
         end else begin
            stall_cnt_q <= '0;
         end
         if (state_q == DRAIN && idle_i) begin
            timeout_q <= 1'b0;
         end
      end
   end

   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_chan_arbiter.sv
// Self-checking bench for cdc_chan_arbiter: vector table, scoreboard, flush/watchdog/reset sequences.
module tb_cdc_chan_arbiter;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int IW  = 2;
   localparam int OW  = DW + IW;
   localparam int CLR = 2;
   localparam int TO  = 16;
`ifdef CDC_CHAN_ARB_TIMEOUT_EN
   localparam logic EXP_TO = 1'b1;
`else
   localparam logic EXP_TO = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_ni;
   logic [N-1:0][DW-1:0]  inp_data;
   logic [N-1:0]          inp_valid;
   logic [N-1:0]          inp_ready;
   logic [OW-1:0]         oup_data;
   logic                  oup_valid;
   logic                  oup_ready;
   logic                  idle;
   logic                  clr;
   logic                  flush_req;
   logic                  flush_ack;
   logic                  timeout;

   typedef struct {
      logic [N-1:0] valid;
      logic [N-1:0] exp_gnt;
   } vec_t;

   vec_t          vecs[13];
   logic [OW-1:0] sb_q[$];
   logic [OW-1:0] mon_exp;
   int            n_tests = 0;
   int            n_fail  = 0;

   always #5 clk = ~clk;

   cdc_chan_arbiter #(
      .NumInp        (N),
      .DataWidth     (DW),
      .ClrCycles     (CLR),
      .TimeoutCycles (TO)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .inp_data_i  (inp_data),
      .inp_valid_i (inp_valid),
      .inp_ready_o (inp_ready),
      .oup_data_o  (oup_data),
      .oup_valid_o (oup_valid),
      .oup_ready_i (oup_ready),
      .idle_i      (idle),
      .clr_o       (clr),
      .flush_req_i (flush_req),
      .flush_ack_o (flush_ack),
      .timeout_o   (timeout)
   );

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic int oh2idx(input logic [N-1:0] oh);
      int r = 0;
      for (int k = 0; k < N; k++) if (oh[k]) r = k;
      return r;
   endfunction

   task automatic push_grant(input logic [N-1:0] oh);
      int k;
      k = oh2idx(oh);
      sb_q.push_back({IW'(k), inp_data[k]});
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_data;
      for (int k = 0; k < N; k++) inp_data[k] = $urandom();
   endtask

   // Scoreboard consumer: every output handshake must match the oldest grant.
   always @(negedge clk) begin
      if (rst_ni && oup_valid && oup_ready) begin
         if (sb_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
         end else begin
            mon_exp = sb_q.pop_front();
            check("sb_data", oup_data, mon_exp);
         end
      end
   end

   task automatic flush_seq(input int dly, input logic [N-1:0] vmask, input logic [N-1:0] exp_gnt);
      int   clr_cnt, clr_first, ack_first;
      logic saw_ready;
      clr_cnt   = 0;
      clr_first = -1;
      ack_first = -1;
      saw_ready = 1'b0;
      inp_valid = vmask;
      flush_req = 1'b1;
      idle      = (dly == 0);
      oup_ready = 1'b0;
      #1;
      saw_ready |= |inp_ready;
      for (int c = 1; c <= 60 && ack_first < 0; c++) begin
         step;
         if (c == dly) idle = 1'b1;
         #1;
         saw_ready |= |inp_ready;
         if (clr) begin
            clr_cnt++;
            if (clr_first < 0) clr_first = c;
         end
         if (flush_ack) ack_first = c;
      end
      check("flush_ack_seen", 64'(ack_first >= 0), 64'd1);
      check("flush_no_grant", 64'(saw_ready), 64'd0);
      check("flush_clr_len", 64'(clr_cnt), 64'(CLR));
      check("flush_clr_start", 64'(clr_first), 64'(((dly == 0) ? 1 : dly) + 1));
      check("flush_ack_start", 64'(ack_first), 64'(clr_first + CLR));
      check("flush_timeout_clr", 64'(timeout), 64'd0);
      flush_req = 1'b0;
      idle      = 1'b0;
      oup_ready = 1'b1;
      step;
      check("flush_ack_hold", 64'(flush_ack), 64'd1);
      check("flush_regrant", 64'(inp_ready), 64'(exp_gnt));
      if (exp_gnt != '0) push_grant(exp_gnt);
      step;
      inp_valid = '0;
      #1;
      check("flush_ack_fall", 64'(flush_ack), 64'd0);
      check("flush_post_valid", 64'(oup_valid), 64'(exp_gnt != '0));
      step;
   endtask

   initial begin
      int pulses;

      vecs[0]  = '{4'b1111, 4'b0001};
      vecs[1]  = '{4'b1111, 4'b0010};
      vecs[2]  = '{4'b1111, 4'b0100};
      vecs[3]  = '{4'b1111, 4'b1000};
      vecs[4]  = '{4'b1111, 4'b0001};
      vecs[5]  = '{4'b0001, 4'b0001};
      vecs[6]  = '{4'b1000, 4'b1000};
      vecs[7]  = '{4'b0110, 4'b0010};
      vecs[8]  = '{4'b0011, 4'b0001};
      vecs[9]  = '{4'b1100, 4'b0100};
      vecs[10] = '{4'b0101, 4'b0001};
      vecs[11] = '{4'b0000, 4'b0000};
      vecs[12] = '{4'b0100, 4'b0100};

      rst_ni    = 1'b0;
      inp_data  = '0;
      inp_valid = 4'b1111;
      oup_ready = 1'b0;
      idle      = 1'b0;
      flush_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", 64'(inp_ready), 64'd0);
      check("rst_valid", 64'(oup_valid), 64'd0);
      check("rst_data", 64'(oup_data), 64'd0);
      check("rst_clr", 64'(clr), 64'd0);
      check("rst_ack", 64'(flush_ack), 64'd0);
      check("rst_timeout", 64'(timeout), 64'd0);
      inp_valid = '0;
      rst_ni    = 1'b1;
      step;

      // Arbitration table: one IDLE/LOCKED pair per entry, ready always high.
      for (int e = 0; e < 13; e++) begin
         randomize_data();
         inp_valid = vecs[e].valid;
         oup_ready = 1'b1;
         #1;
         check("arb_gnt", 64'(inp_ready), 64'(vecs[e].exp_gnt));
         if (vecs[e].exp_gnt != '0) begin
            push_grant(vecs[e].exp_gnt);
            step;
            inp_valid = '0;
            #1;
            check("arb_locked_valid", 64'(oup_valid), 64'd1);
            check("arb_locked_idx", 64'(oup_data[OW-1:DW]), 64'(oh2idx(vecs[e].exp_gnt)));
            check("arb_locked_noready", 64'(inp_ready), 64'd0);
         end
         step;
      end

      // Backpressure: lone requester 2, ten stalled cycles, one accept pulse.
      inp_data[2] = 32'hA5A5_A5A5;
      inp_valid   = 4'b0100;
      oup_ready   = 1'b0;
      #1;
      check("bp_gnt", 64'(inp_ready), 64'(4'b0100));
      push_grant(4'b0100);
      pulses = 0;
      pulses += int'(inp_ready[2]);
      for (int c = 0; c < 10; c++) begin
         step;
         #1;
         pulses += int'(inp_ready[2]);
         check("bp_valid", 64'(oup_valid), 64'd1);
         check("bp_data", 64'(oup_data), 64'({2'd2, 32'hA5A5_A5A5}));
      end
      inp_valid = '0;
      oup_ready = 1'b1;
      step;
      #1;
      pulses += int'(inp_ready[2]);
      check("bp_pulses", 64'(pulses), 64'd1);
      check("bp_released", 64'(oup_valid), 64'd0);

      // Flush from IDLE with a 5-cycle drain wait, then a collision with requester 1.
      flush_seq(5, 4'b0000, 4'b0000);
      randomize_data();
      flush_seq(0, 4'b0010, 4'b0010);

      // Flush raised in LOCKED: item completes first, rr pointer survives.
      randomize_data();
      inp_valid = 4'b1111;
      oup_ready = 1'b0;
      #1;
      check("lk_gnt", 64'(inp_ready), 64'(4'b0100));
      push_grant(4'b0100);
      step;
      flush_req = 1'b1;
      #1;
      check("lk_valid", 64'(oup_valid), 64'd1);
      step;
      check("lk_still_valid", 64'(oup_valid), 64'd1);
      check("lk_no_clr", 64'(clr), 64'd0);
      oup_ready = 1'b1;
      step;
      flush_seq(1, 4'b1111, 4'b1000);

      // Watchdog stall then flush; result depends on the build option.
      randomize_data();
      inp_valid = 4'b0001;
      oup_ready = 1'b0;
      #1;
      check("wd_gnt", 64'(inp_ready), 64'(4'b0001));
      push_grant(4'b0001);
      step;
      inp_valid = '0;
      repeat (TO - 1) step;
      check("wd_before", 64'(timeout), 64'd0);
      step;
      check("wd_at", 64'(timeout), 64'(EXP_TO));
      oup_ready = 1'b1;
      step;
      check("wd_sticky", 64'(timeout), 64'(EXP_TO));
      flush_seq(2, 4'b0000, 4'b0000);

      // Reset mid-LOCKED discards the item and clears the pointer.
      randomize_data();
      inp_valid = 4'b1111;
      oup_ready = 1'b0;
      #1;
      check("mr_gnt", 64'(inp_ready), 64'(4'b0010));
      step;
      #2;
      rst_ni = 1'b0;
      #1;
      check("mr_valid", 64'(oup_valid), 64'd0);
      check("mr_data", 64'(oup_data), 64'd0);
      check("mr_ready", 64'(inp_ready), 64'd0);
      check("mr_clr_ack_to", 64'({clr, flush_ack, timeout}), 64'd0);
      step;
      rst_ni = 1'b1;
      #1;
      check("mr_regrant", 64'(inp_ready), 64'(4'b0001));
      push_grant(4'b0001);
      oup_ready = 1'b1;
      step;
      inp_valid = '0;
      step;
      step;
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
